note_mixer: RTL and testbench
=============================

NOTE_MIXER -- requirements
Module: note_mixer

Interface
REQ-001 SHALL have parameter NCH, default 4, number of mixed channels (legal range 1..16).
REQ-002 SHALL have parameter VOLW, default 4, per-channel volume width in bits (legal range 1..8).
REQ-003 SHALL have parameter SDIV, default 16, sample-tick period in baseclk cycles (legal range 2..65535).
REQ-004 SHALL have port baseclk, input, 1, the single clock; all state is on its rising edge.
REQ-005 SHALL have port asyncrst_n, input, 1, the reset; it is asynchronous and active-low.
REQ-006 SHALL have port wave_in, input, NCH, the 1-bit channel waveforms from the note_synthesizer instances; bit k is channel k.
REQ-007 SHALL have port mute, input, NCH, per-channel mute; 1 forces the channel's contribution to 0.
REQ-008 SHALL have port vol_we, input, 1, volume write strobe, one cycle per write.
REQ-009 SHALL have port vol_wsel, input, 4, channel index for the volume write.
REQ-010 SHALL have port vol_wdata, input, VOLW, volume value for the write.
REQ-011 SHALL have port buzzerout, output, 1, delta-sigma modulated mix that drives the buzzer pin.
REQ-012 SHALL have port level, output, VOLW+4, registered mix sum.
REQ-013 SHALL have port sample_tick, output, 1, a one-cycle pulse marking each sample update.

Function
REQ-014 SHALL register wave_in into wave_q every cycle; wave_in SHALL be used only through wave_q.
REQ-015 SHALL run a tick counter 0..SDIV-1 that wraps to 0; sample_tick SHALL be 1 in the cycle the counter equals SDIV-1.
REQ-016 SHALL, on the edge ending a sample_tick cycle, load level with sum over k of (wave_q[k] & ~mute[k]) ? vol_eff[k] : 0, computed at full width with no overflow; level SHALL hold between ticks.
REQ-017 SHALL define FULL = NCH*(2^VOLW-1) as a constant of width VOLW+4.
REQ-018 SHALL run every cycle: err = acc + level at width VOLW+5; if err >= FULL then buzzerout<=1 and acc<=err-FULL, else buzzerout<=0 and acc<=err.
REQ-019 SHALL make the long-run buzzerout high density exactly level/FULL; level=0 SHALL give constant 0 and level=FULL SHALL give constant 1.
REQ-020 SHALL, on vol_we=1 with vol_wsel<NCH, write vol_wdata to the target volume vol_tgt[vol_wsel].
REQ-021 SHALL ignore a write with vol_wsel>=NCH, with no state change.
REQ-022 SHALL give a write and a tick in the same cycle this effect: the tick uses the pre-write vol_eff.
REQ-023 SHALL apply a change to mute or wave_in only at the next tick, so the latency from an input change to level is at most SDIV+1 cycles.

Reset
REQ-024 SHALL, while asyncrst_n=0, immediately force: buzzerout=0, level=0, sample_tick=0, acc=0, tick counter=0, wave_q=0, and every vol_tgt and vol_eff = 2^VOLW-1.
REQ-025 SHALL, after reset release, produce the first sample_tick in the SDIV-th cycle.
REQ-026 SHALL, on reset asserted mid-operation, discard all state, including a pending ramp and the accumulator residue.

Configuration
REQ-027 SHALL support the macro NOTE_MIXER_RAMP_EN.
REQ-028 SHALL, when NOTE_MIXER_RAMP_EN is defined, on each sample_tick edge move each vol_eff[k] one step toward vol_tgt[k] (+1 or -1), reaching target after |delta| ticks; level uses the pre-step vol_eff.
REQ-029 SHALL, when NOTE_MIXER_RAMP_EN is undefined, make vol_eff identical to vol_tgt, so a write takes effect at the next tick.

Verification (NCH=4, VOLW=4, SDIV=16, FULL=60)
REQ-030 SHALL cover: reset asserted mid-stream -> buzzerout=0 and level=0 at once; after release, sample_tick is first high in cycle 16 and all volumes read back as 15.
REQ-031 SHALL cover: wave_in=4'b1111, mute=0 -> level=60 after the first tick; buzzerout then stays 1 on every cycle.
REQ-032 SHALL cover: wave_in=4'b0001, vol0=15 -> level=15; buzzerout is high exactly 1 cycle in every 4 over 240 cycles.
REQ-033 SHALL cover: vol_we with vol_wsel=5, vol_wdata=0 -> no change to level; then mute=4'b0001 with wave_in=4'b0001 -> level=0 at the next tick and buzzerout stays 0.
REQ-034 SHALL cover: write vol0=0 from 15 with wave_in=4'b0001 -> with NOTE_MIXER_RAMP_EN, level steps 15,14,...,0 over 16 ticks; without it, level=0 at the next tick.
REQ-035 SHALL cover: write and sample_tick in the same cycle -> that tick uses the old volume, and the new volume applies from the following tick.

Source files
------------

// File: rtl/note_mixer.sv
// note_mixer: volume-weighted mix of NCH 1-bit waves, delta-sigma modulated onto the buzzer pin.
// Latency: wave_in/mute reach level at the next sample tick (<= SDIV+1 cycles); buzzerout follows level one cycle later.
// Backpressure: none; volume writes are accepted every cycle. NOTE_MIXER_RAMP_EN enables per-tick volume ramping.
module note_mixer #(
    parameter int NCH  = 4,
    parameter int VOLW = 4,
    parameter int SDIV = 16
) (
    input  logic            baseclk,
    input  logic            asyncrst_n,
    input  logic [NCH-1:0]  wave_in,
    input  logic [NCH-1:0]  mute,
    input  logic            vol_we,
    input  logic [3:0]      vol_wsel,
    input  logic [VOLW-1:0] vol_wdata,
    output logic            buzzerout,
    output logic [VOLW+3:0] level,
    output logic            sample_tick
);
    localparam int              LW   = VOLW + 4;
    localparam logic [VOLW-1:0] VMAX = {VOLW{1'b1}};
    localparam logic [LW-1:0]   FULL = LW'(NCH * ((1 << VOLW) - 1));
    localparam logic [15:0]     TMAX = 16'(SDIV - 1);

    logic [NCH-1:0]  wave_q;
    logic [15:0]     tick_cnt;
    logic [LW-1:0]   acc;
    logic [LW-1:0]   mix_sum;
    logic [LW:0]     err;
    logic [VOLW-1:0] vol_tgt [NCH];
    logic [VOLW-1:0] vol_eff [NCH];

    assign sample_tick = (tick_cnt == TMAX);

    always_ff @(posedge baseclk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            tick_cnt <= '0;
        end else if (sample_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // NCH*(2^VOLW-1) < 2^(VOLW+4) for NCH<=16, so the sum never overflows LW bits.
    always_comb begin
        mix_sum = '0;
        for (int k = 0; k < NCH; k++) begin
            if (wave_q[k] && !mute[k]) begin
                mix_sum = mix_sum + LW'(vol_eff[k]);
            end
        end
    end

    // Selects >= NCH match no channel, so such writes leave all state untouched.
    always_ff @(posedge baseclk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            for (int k = 0; k < NCH; k++) begin
                vol_tgt[k] <= VMAX;
            end
        end else if (vol_we) begin
            for (int k = 0; k < NCH; k++) begin
                if (vol_wsel == 4'(k)) begin
                    vol_tgt[k] <= vol_wdata;
                end
            end
        end
    end

`ifdef NOTE_MIXER_RAMP_EN
    // One LSB per tick toward target; the mix in the same tick sees the pre-step value.
    always_ff @(posedge baseclk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            for (int k = 0; k < NCH; k++) begin
                vol_eff[k] <= VMAX;
            end
        end else if (sample_tick) begin
            for (int k = 0; k < NCH; k++) begin
                if (vol_eff[k] < vol_tgt[k]) begin
                    vol_eff[k] <= vol_eff[k] + 1'b1;
                end else if (vol_eff[k] > vol_tgt[k]) begin
                    vol_eff[k] <= vol_eff[k] - 1'b1;
                end
            end
        end
    end
`else
    assign vol_eff = vol_tgt;
`endif

    assign err = {1'b0, acc} + {1'b0, level};

    // First-order delta-sigma: acc stays below FULL, so high density is exactly level/FULL.
    always_ff @(posedge baseclk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            wave_q    <= '0;
            level     <= '0;
            acc       <= '0;
            buzzerout <= 1'b0;
        end else begin
            wave_q <= wave_in;
            if (sample_tick) begin
                level <= mix_sum;
            end
            if (err >= {1'b0, FULL}) begin
                buzzerout <= 1'b1;
                acc       <= LW'(err - {1'b0, FULL});
            end else begin
                buzzerout <= 1'b0;
                acc       <= LW'(err);
            end
        end
    end

endmodule

// File: tb/tb_note_mixer.sv
// Bench for note_mixer at NCH=4, VOLW=4, SDIV=16 (FULL=60): level values are scoreboarded
// per sample tick; buzzer density, volume writes and reset behaviour are checked inline.
module tb_note_mixer;
    localparam int NCH  = 4;
    localparam int VOLW = 4;
    localparam int SDIV = 16;

    logic            baseclk = 1'b0;
    logic            asyncrst_n = 1'b0;
    logic [NCH-1:0]  wave_in = '0;
    logic [NCH-1:0]  mute = '0;
    logic            vol_we = 1'b0;
    logic [3:0]      vol_wsel = '0;
    logic [VOLW-1:0] vol_wdata = '0;
    logic            buzzerout;
    logic [VOLW+3:0] level;
    logic            sample_tick;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    note_mixer #(.NCH(NCH), .VOLW(VOLW), .SDIV(SDIV)) dut (
        .baseclk    (baseclk),
        .asyncrst_n (asyncrst_n),
        .wave_in    (wave_in),
        .mute       (mute),
        .vol_we     (vol_we),
        .vol_wsel   (vol_wsel),
        .vol_wdata  (vol_wdata),
        .buzzerout  (buzzerout),
        .level      (level),
        .sample_tick(sample_tick)
    );

    always #5 baseclk = ~baseclk;

    // Returns at the falling edge just after a tick edge (tick counter back at 0).
    task automatic next_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 2 * SDIV && !seen; i++) begin
            @(negedge baseclk);
            if (sample_tick) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL tick_timeout sample_tick got 0 expected 1 within %0d cycles", 2 * SDIV);
        end
        @(negedge baseclk);
    endtask

    task automatic test_reset();
        int cyc;
        int exp;
        bit found;
        asyncrst_n = 1'b0;
        repeat (3) @(negedge baseclk);
        checks++;
        if (level !== 8'd0) begin errors++; $display("FAIL reset_level got %0d expected 0", level); end
        checks++;
        if (buzzerout !== 1'b0) begin errors++; $display("FAIL reset_buzz got %b expected 0", buzzerout); end
        checks++;
        if (sample_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b expected 0", sample_tick); end
        asyncrst_n = 1'b1;
        cyc = 1;
        found = 1'b0;
        while (!found && cyc < 3 * SDIV) begin
            @(negedge baseclk);
            cyc++;
            if (sample_tick) found = 1'b1;
        end
        checks++;
        if (!found || cyc != SDIV) begin
            errors++;
            $display("FAIL first_tick got cycle %0d expected %0d", cyc, SDIV);
        end
        exp_q.push_back(0);
        @(negedge baseclk);
        exp = exp_q.pop_front();
        checks++;
        if (level !== 8'(exp)) begin errors++; $display("FAIL idle_level got %0d expected %0d", level, exp); end
    endtask

    task automatic test_full_scale();
        int exp;
        next_tick();
        wave_in = 4'b1111;
        mute    = 4'b0000;
        exp_q.push_back(60);
        next_tick();
        exp = exp_q.pop_front();
        checks++;
        if (level !== 8'(exp)) begin errors++; $display("FAIL full_level got %0d expected %0d", level, exp); end
        @(negedge baseclk);
        for (int i = 0; i < 2 * SDIV; i++) begin
            @(negedge baseclk);
            checks++;
            if (buzzerout !== 1'b1) begin errors++; $display("FAIL full_buzz cycle %0d got %b expected 1", i, buzzerout); end
        end
    endtask

    task automatic test_single_channel();
        int exp;
        int total;
        int blk;
        next_tick();
        wave_in = 4'b0001;
        exp_q.push_back(15);
        next_tick();
        exp = exp_q.pop_front();
        checks++;
        if (level !== 8'(exp)) begin errors++; $display("FAIL single_level got %0d expected %0d", level, exp); end
        @(negedge baseclk);
        total = 0;
        for (int b = 0; b < 60; b++) begin
            blk = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge baseclk);
                if (buzzerout === 1'b1) blk++;
            end
            total += blk;
            checks++;
            if (blk != 1) begin errors++; $display("FAIL density_block %0d got %0d highs expected 1", b, blk); end
        end
        checks++;
        if (total != 60) begin errors++; $display("FAIL density_total got %0d expected 60", total); end
    endtask

    task automatic test_bad_sel_and_mute();
        int exp;
        next_tick();
        vol_we    = 1'b1;
        vol_wsel  = 4'd5;
        vol_wdata = 4'd0;
        @(negedge baseclk);
        vol_we = 1'b0;
        exp_q.push_back(15);
        next_tick();
        exp = exp_q.pop_front();
        checks++;
        if (level !== 8'(exp)) begin errors++; $display("FAIL bad_sel_level got %0d expected %0d", level, exp); end
        mute = 4'b0001;
        exp_q.push_back(0);
        next_tick();
        exp = exp_q.pop_front();
        checks++;
        if (level !== 8'(exp)) begin errors++; $display("FAIL mute_level got %0d expected %0d", level, exp); end
        @(negedge baseclk);
        for (int i = 0; i < 2 * SDIV; i++) begin
            @(negedge baseclk);
            checks++;
            if (buzzerout !== 1'b0) begin errors++; $display("FAIL mute_buzz cycle %0d got %b expected 0", i, buzzerout); end
        end
    endtask

    task automatic test_vol_ramp();
        int exp;
        next_tick();
        mute      = 4'b0000;
        vol_we    = 1'b1;
        vol_wsel  = 4'd0;
        vol_wdata = 4'd0;
        @(negedge baseclk);
        vol_we = 1'b0;
`ifdef NOTE_MIXER_RAMP_EN
        for (int v = 15; v >= 0; v--) exp_q.push_back(v);
`else
        exp_q.push_back(0);
        exp_q.push_back(0);
`endif
        while (exp_q.size() > 0) begin
            next_tick();
            exp = exp_q.pop_front();
            checks++;
            if (level !== 8'(exp)) begin errors++; $display("FAIL ramp_level got %0d expected %0d", level, exp); end
        end
    endtask

    task automatic test_write_on_tick();
        int exp;
        next_tick();
        repeat (SDIV - 1) @(negedge baseclk);
        checks++;
        if (sample_tick !== 1'b1) begin errors++; $display("FAIL tick_align got %b expected 1", sample_tick); end
        vol_we    = 1'b1;
        vol_wsel  = 4'd0;
        vol_wdata = 4'd9;
        exp_q.push_back(0);
        @(negedge baseclk);
        vol_we = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (level !== 8'(exp)) begin errors++; $display("FAIL same_cycle_level got %0d expected %0d", level, exp); end
`ifdef NOTE_MIXER_RAMP_EN
        for (int v = 0; v <= 9; v++) exp_q.push_back(v);
`else
        exp_q.push_back(9);
        exp_q.push_back(9);
`endif
        while (exp_q.size() > 0) begin
            next_tick();
            exp = exp_q.pop_front();
            checks++;
            if (level !== 8'(exp)) begin errors++; $display("FAIL after_write_level got %0d expected %0d", level, exp); end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int exp;
        bit found;
        repeat (5) @(negedge baseclk);
        #2;
        asyncrst_n = 1'b0;
        #1;
        checks++;
        if (level !== 8'd0) begin errors++; $display("FAIL midrst_level got %0d expected 0", level); end
        checks++;
        if (buzzerout !== 1'b0) begin errors++; $display("FAIL midrst_buzz got %b expected 0", buzzerout); end
        repeat (2) @(negedge baseclk);
        wave_in = 4'b1111;
        mute    = 4'b0000;
        asyncrst_n = 1'b1;
        cyc = 1;
        found = 1'b0;
        while (!found && cyc < 3 * SDIV) begin
            @(negedge baseclk);
            cyc++;
            if (sample_tick) found = 1'b1;
        end
        checks++;
        if (!found || cyc != SDIV) begin
            errors++;
            $display("FAIL midrst_first_tick got cycle %0d expected %0d", cyc, SDIV);
        end
        // All four volumes back at 15 gives the full-scale sum.
        exp_q.push_back(60);
        @(negedge baseclk);
        exp = exp_q.pop_front();
        checks++;
        if (level !== 8'(exp)) begin errors++; $display("FAIL midrst_vols got %0d expected %0d", level, exp); end
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_single_channel();
        test_bad_sel_and_mute();
        test_vol_ramp();
        test_write_on_tick();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
